// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates nickels, dimes and quarters,
// vends one item at PRICE, and returns excess or cancelled credit as change.
module vend_controller #(
  parameter int unsigned PRICE = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       cancel,
  input  logic       change_ack,
  output logic       dispense,
  output logic       change_valid,
  output logic [7:0] change,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_COLLECT  = 2'b01,
    S_DISPENSE = 2'b10,
    S_CHANGE   = 2'b11
  } state_e;

  localparam logic [8:0] PRICE_S = 9'(PRICE);
  localparam logic [7:0] PRICE_C = 8'(PRICE);

  state_e     state_q;
  logic [7:0] credit_q;
  logic [7:0] coin_val;
  logic [8:0] sum_s;
  logic [7:0] leftover;
  logic       busy;
  logic       cancel_req;

  always_comb begin
    coin_val = 8'd0;
    case (coin)
      2'b01:   coin_val = 8'd5;
      2'b10:   coin_val = 8'd10;
      2'b11:   coin_val = 8'd25;
      default: coin_val = 8'd0;
    endcase
  end

  // Credit never exceeds PRICE+20, so the 9-bit sum always fits back in 8 bits.
  assign sum_s      = {1'b0, credit_q} + {1'b0, coin_val};
  assign leftover   = credit_q - PRICE_C;
  assign busy       = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
  // IDLE always holds zero credit, so cancel only means something in COLLECT.
  assign cancel_req = cancel && (state_q == S_COLLECT);

  // NOTE: coin_reject is intentionally combinational so the coin source learns
  // within the same cycle that its coin was not taken.
  assign coin_reject = (coin != 2'b00) && (busy || cancel_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (cancel_req) begin
            state_q <= S_CHANGE;
          end else begin
            credit_q <= sum_s[7:0];
            if (sum_s >= PRICE_S)    state_q <= S_DISPENSE;
            else if (sum_s != 9'd0)  state_q <= S_COLLECT;
          end
        end
        S_DISPENSE: begin
          credit_q <= leftover;
          state_q  <= (leftover != 8'd0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          if (change_ack) begin
            credit_q <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          credit_q <= '0;
        end
      endcase
    end
  end

  assign dispense     = (state_q == S_DISPENSE);
  assign change_valid = (state_q == S_CHANGE);
  assign change       = change_valid ? credit_q : 8'd0;
  assign credit       = credit_q;
  assign state        = state_q;

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE, default 15, item price in cents; legal range 5..230, multiple of 5.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port coin  input  2  coin this cycle: 00 none, 01 nickel (5), 10 dime (10), 11 quarter (25).
REQ-005 SHALL have port cancel  input  1  refund request, sampled each cycle.
REQ-006 SHALL have port change_ack  input  1  downstream has taken the presented change.
REQ-007 SHALL have port dispense  output  1  one-cycle vend pulse.
REQ-008 SHALL have port change_valid  output  1  change/refund amount is presented.
REQ-009 SHALL have port change  output  8  change/refund in cents; 0 when change_valid=0.
REQ-010 SHALL have port credit  output  8  current accumulated credit in cents.
REQ-011 SHALL have port coin_reject  output  1  coin presented this cycle was not accepted.
REQ-012 SHALL have port state  output  2  current FSM state encoding, for debug.

Function
REQ-013 SHALL implement a 4-state FSM: IDLE=00, COLLECT=01, DISPENSE=10, CHANGE=11; all outputs are registered or Moore-decoded from state/credit, except coin_reject, which is combinational from coin and state.
REQ-014 SHALL define coin value v: 0/5/10/25 per the coin code; sum s = credit + v, computed 9 bits wide.
REQ-015 SHALL, in IDLE or COLLECT with cancel=0: credit <= s; next state DISPENSE if s >= PRICE, else COLLECT if s > 0, else stay.
REQ-016 SHALL, in COLLECT with cancel=1: next state CHANGE, credit unchanged; a coin in the same cycle is rejected (coin_reject=1) and not added.
REQ-017 SHALL ignore cancel in IDLE when credit=0; a coin in that cycle is accepted per REQ-015.
REQ-018 SHALL assert dispense=1 for exactly the single cycle spent in DISPENSE; on leaving it, credit <= credit - PRICE.
REQ-019 SHALL leave DISPENSE for CHANGE if credit - PRICE > 0, else for IDLE.
REQ-020 SHALL, in CHANGE, hold change_valid=1 and change=credit stable until change_ack=1; on the ack edge: credit <= 0, next state IDLE.
REQ-021 SHALL ignore change_ack outside CHANGE.
REQ-022 SHALL, in DISPENSE and CHANGE, not accumulate coins: any nonzero coin gives coin_reject=1 that cycle, and credit is unaffected; cancel is ignored.
REQ-023 SHALL keep coin_reject=0 whenever coin=00.
REQ-024 SHALL never overflow credit: maximum reachable credit is PRICE+20 <= 250 under the REQ-001 range.
REQ-025 SHALL vend at most one item per DISPENSE visit; excess credit is always returned as change, never carried over.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, credit=0, dispense=0, change_valid=0, change=0, regardless of clk.
REQ-027 SHALL discard any pending credit or change on reset mid-transaction, with no dispense pulse emitted.
REQ-028 SHALL, with coin=00, leave all outputs at reset values after rst deasserts, and accept a coin on the first rising edge after deassertion.

Verification (PRICE=15)
REQ-029 SHALL cover exact pay: dime then nickel on consecutive cycles -> credit 10 then 15, dispense pulse next cycle, back to IDLE, change_valid never high.
REQ-030 SHALL cover overpay: quarter in IDLE -> DISPENSE, dispense=1 for one cycle, then CHANGE with change=10; change_ack held low 3 cycles keeps change=10; ack -> IDLE, credit=0.
REQ-031 SHALL cover cancel: nickel, nickel, then cancel with a dime in the same cycle -> coin_reject=1, CHANGE with change=10, no dispense.
REQ-032 SHALL cover a busy reject: a quarter during DISPENSE and during CHANGE -> coin_reject=1, change value unchanged, credit unchanged.
REQ-033 SHALL cover async reset: rst pulsed between clock edges while in CHANGE with change=10 -> outputs cleared before the next edge, state=IDLE, no dispense.
REQ-034 SHALL cover boundary: nickel x2 then quarter -> s=35, dispense, change=20.
